// File: rtl/adc_parallel_interface.sv
// Receive-side interface for a parallel-output ADC: divides SYS_CLK into ADC_CLK and
// captures ADC_D/ADC_DTR mid-period, delivering words with a one-cycle valid strobe.
module adc_parallel_interface #(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 10
) (
   input  logic              SYS_CLK,
   input  logic              RESET_N,
   output logic [DATA_W-1:0] APP_DATA,
   output logic              APP_DATA_VALID,
   output logic              ADC_CLK,
   input  logic              ADC_DTR,
   input  logic [DATA_W-1:0] ADC_D
);
   localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0]  div_cnt_r;
   logic [CNT_W-1:0]  div_cnt_nxt_s;
   logic              adc_clk_r;
   logic              adc_clk_nxt_s;
   logic              wrap_s;
   logic              fall_evt_s;

   logic [DATA_W-1:0] cap_data_r;
   logic [DATA_W-1:0] cap_data_nxt_s;
   logic              cap_vld_r;
   logic              cap_vld_nxt_s;
   logic [DATA_W-1:0] app_data_r;
   logic [DATA_W-1:0] app_data_nxt_s;
   logic              out_vld_r;
   logic              out_vld_nxt_s;

   // Divider next state: ADC_CLK toggles whenever the half-period counter wraps
   always_comb begin
      wrap_s        = (div_cnt_r == CNT_MAX);
      fall_evt_s    = wrap_s & adc_clk_r;
      div_cnt_nxt_s = div_cnt_r;
      adc_clk_nxt_s = adc_clk_r;
      if (wrap_s) begin
         div_cnt_nxt_s = {CNT_W{1'b0}};
         adc_clk_nxt_s = ~adc_clk_r;
      end else begin
         div_cnt_nxt_s = div_cnt_r + CNT_W'(1);
         adc_clk_nxt_s = adc_clk_r;
      end
   end

   // Two-stage capture pipeline, advanced only on the ADC_CLK falling event
   always_comb begin
      cap_data_nxt_s = cap_data_r;
      cap_vld_nxt_s  = cap_vld_r;
      app_data_nxt_s = app_data_r;
      out_vld_nxt_s  = 1'b0;
      if (fall_evt_s) begin
         cap_data_nxt_s = ADC_D;
         cap_vld_nxt_s  = ADC_DTR;
         app_data_nxt_s = cap_data_r;
         out_vld_nxt_s  = cap_vld_r;
      end else begin
         out_vld_nxt_s  = 1'b0;
      end
   end

   // State registers; reset forces ADC_CLK low and empties the pipeline
   always_ff @(posedge SYS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         div_cnt_r  <= {CNT_W{1'b0}};
         adc_clk_r  <= 1'b0;
         cap_data_r <= {DATA_W{1'b0}};
         cap_vld_r  <= 1'b0;
         app_data_r <= {DATA_W{1'b0}};
         out_vld_r  <= 1'b0;
      end else begin
         div_cnt_r  <= div_cnt_nxt_s;
         adc_clk_r  <= adc_clk_nxt_s;
         cap_data_r <= cap_data_nxt_s;
         cap_vld_r  <= cap_vld_nxt_s;
         app_data_r <= app_data_nxt_s;
         out_vld_r  <= out_vld_nxt_s;
      end
   end

   assign ADC_CLK        = adc_clk_r;
   assign APP_DATA       = app_data_r;
   assign APP_DATA_VALID = out_vld_r;

endmodule

// File: tb/tb_adc_parallel_interface.sv
// Bench for adc_parallel_interface: directed word table, random word stream and
// reset scenarios, checked against a launched-word history model at CLK_DIV 2 and 4.
module tb_adc_parallel_interface;
   localparam int DATA_W = 10;
   localparam int DIV_A  = 2;
   localparam int DIV_B  = 4;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              dtr;
   } word_t;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              dtr;
      logic [DATA_W-1:0] exp_app;
      int                exp_pulses;
   } vec_t;

   logic              sys_clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [DATA_W-1:0] app_data_a, app_data_b;
   logic              app_vld_a, app_vld_b;
   logic              adc_clk_a, adc_clk_b;
   logic [DATA_W-1:0] adc_d_a = '0;
   logic [DATA_W-1:0] adc_d_b = '0;
   logic              adc_dtr_a = 1'b1;
   logic              adc_dtr_b = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   word_t src_q[$];
   word_t w_q[$];
   vec_t  tbl[11];
   int    cyc = 0, rel_cyc = 0;
   int    rises_a = 0, pulses_a = 0, last_rise_a = 0;
   int    rises_b = 0, pulses_b = 0, last_rise_b = 0;
   logic  clk_prev_a = 1'b0, clk_prev_b = 1'b0, vld_prev_a = 1'b0;
   logic [DATA_W-1:0] seen_app_a = '0;
   int    seen_pulses_a = 0;

   always #10 sys_clk = ~sys_clk;

   adc_parallel_interface #(.CLK_DIV(DIV_A), .DATA_W(DATA_W)) u_dut_a (
      .SYS_CLK(sys_clk), .RESET_N(reset_n), .APP_DATA(app_data_a),
      .APP_DATA_VALID(app_vld_a), .ADC_CLK(adc_clk_a), .ADC_DTR(adc_dtr_a), .ADC_D(adc_d_a));

   adc_parallel_interface #(.CLK_DIV(DIV_B), .DATA_W(DATA_W)) u_dut_b (
      .SYS_CLK(sys_clk), .RESET_N(reset_n), .APP_DATA(app_data_b),
      .APP_DATA_VALID(app_vld_b), .ADC_CLK(adc_clk_b), .ADC_DTR(adc_dtr_b), .ADC_D(adc_d_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One SYS_CLK cycle: sample on the falling edge, score both instances, act as the ADCs
   task automatic step(output logic rose_a);
      word_t nw;
      logic [DATA_W-1:0] exp_d;
      @(negedge sys_clk);
      cyc++;
      rose_a = 1'b0;
      if (app_vld_a) begin
         check("a_vld_width", {31'd0, vld_prev_a}, 32'd0);
         pulses_a++;
         if (rises_a >= 2 && w_q[rises_a-2].dtr)
            check("a_vld_data", app_data_a, w_q[rises_a-2].d);
         else
            check("a_vld_spurious", {31'd0, app_vld_a}, 32'd0);
      end
      vld_prev_a = app_vld_a;
      if (adc_clk_a && !clk_prev_a) begin
         rises_a++;
         rose_a = 1'b1;
         if (rises_a == 1) check("a_first_rise", cyc - rel_cyc, DIV_A);
         else              check("a_period", cyc - last_rise_a, 2 * DIV_A);
         last_rise_a = cyc;
         exp_d = (rises_a >= 3) ? w_q[rises_a-3].d : '0;
         check("a_app_at_rise", app_data_a, exp_d);
         if (rises_a >= 2)
            check("a_pulses", pulses_a, (rises_a >= 3 && w_q[rises_a-3].dtr) ? 1 : 0);
         seen_app_a    = app_data_a;
         seen_pulses_a = pulses_a;
         pulses_a      = 0;
         if (src_q.size() > 0) begin
            nw = src_q.pop_front();
         end else begin
            nw.d   = DATA_W'($urandom);
            nw.dtr = ($urandom_range(0, 3) != 0);
         end
         w_q.push_back(nw);
         adc_d_a   = nw.d;
         adc_dtr_a = nw.dtr;
      end
      clk_prev_a = adc_clk_a;
      if (app_vld_b) pulses_b++;
      if (adc_clk_b && !clk_prev_b) begin
         rises_b++;
         if (rises_b == 1) check("b_first_rise", cyc - rel_cyc, DIV_B);
         else              check("b_period", cyc - last_rise_b, 2 * DIV_B);
         last_rise_b = cyc;
         check("b_app_at_rise", app_data_b, (rises_b >= 3) ? rises_b - 2 : 0);
         if (rises_b >= 2) check("b_pulses", pulses_b, (rises_b >= 3) ? 1 : 0);
         pulses_b = 0;
         adc_d_b  = DATA_W'(rises_b);
      end
      clk_prev_b = adc_clk_b;
   endtask

   task automatic wait_rise();
      logic r;
      int   n;
      r = 1'b0;
      n = 0;
      while (!r && n < 64) begin
         step(r);
         n++;
      end
      if (!r) begin
         n_vec++;
         n_err++;
         $display("FAIL rise_timeout: no ADC_CLK rise within %0d cycles", n);
      end
   endtask

   task automatic hold_and_release();
      logic r;
      for (int i = 0; i < 5; i++) step(r);
      check("rst_adc_clk", {30'd0, adc_clk_a, adc_clk_b}, 32'd0);
      check("rst_app_data", {12'd0, app_data_a, app_data_b}, 32'd0);
      check("rst_valid", {30'd0, app_vld_a, app_vld_b}, 32'd0);
      w_q.delete();
      src_q.delete();
      rises_a = 0; pulses_a = 0; vld_prev_a = 1'b0;
      rises_b = 0; pulses_b = 0;
      adc_d_a = '0; adc_dtr_a = 1'b1; adc_d_b = '0;
      reset_n = 1'b1;
      rel_cyc = cyc;
   endtask

   initial begin
      tbl[0]  = '{10'h001, 1'b1, 10'h000, 0};
      tbl[1]  = '{10'h002, 1'b1, 10'h000, 0};
      tbl[2]  = '{10'h003, 1'b1, 10'h001, 1};
      tbl[3]  = '{10'h004, 1'b1, 10'h002, 1};
      tbl[4]  = '{10'h005, 1'b1, 10'h003, 1};
      tbl[5]  = '{10'h006, 1'b1, 10'h004, 1};
      tbl[6]  = '{10'h155, 1'b0, 10'h005, 1};
      tbl[7]  = '{10'h007, 1'b1, 10'h006, 1};
      tbl[8]  = '{10'h008, 1'b1, 10'h155, 0};
      tbl[9]  = '{10'h009, 1'b1, 10'h007, 1};
      tbl[10] = '{10'h00A, 1'b1, 10'h008, 1};

      hold_and_release();

      for (int i = 0; i < 11; i++) begin
         src_q.push_back('{tbl[i].d, tbl[i].dtr});
         wait_rise();
         check("tbl_app", seen_app_a, tbl[i].exp_app);
         check("tbl_pulses", seen_pulses_a, tbl[i].exp_pulses);
      end

      for (int i = 0; i < 40; i++) wait_rise();

      // Mid-stream reset while ADC_CLK is high: outputs must clear before the next edge
      wait_rise();
      #2;
      reset_n = 1'b0;
      #1;
      check("async_adc_clk", {30'd0, adc_clk_a, adc_clk_b}, 32'd0);
      check("async_app_data", {12'd0, app_data_a, app_data_b}, 32'd0);
      check("async_valid", {30'd0, app_vld_a, app_vld_b}, 32'd0);
      hold_and_release();

      for (int i = 1; i <= 8; i++) begin
         src_q.push_back('{DATA_W'(i), 1'b1});
         wait_rise();
      end
      check("recovery_app", seen_app_a, 32'd6);
      for (int i = 0; i < 12; i++) wait_rise();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
